// File: rtl/hazard_ctrl_param_if.sv
// Datapath <-> hazard controller bundle: hazard-detection inputs, latch control and debug/perf outputs.
interface hazard_ctrl_param_if #(
    parameter int NLATCH = 5,
    parameter int REGW   = 5,
    parameter int CNTW   = 16
);
    logic [REGW-1:0]   rs_id;
    logic [REGW-1:0]   rt_id;
    logic              rs_used;
    logic              rt_used;
    logic              memread_ex;
    logic [REGW-1:0]   wsel_ex;
    logic              branch_taken;
    logic [1:0]        jump_sel;
    logic              ihit;
    logic              dmemreq;
    logic              dhit;
    logic [NLATCH-1:0] freeze;
    logic [NLATCH-1:0] flush;
    logic [1:0]        hz_state;
    logic [CNTW-1:0]   stall_cnt;
    logic [CNTW-1:0]   flush_cnt;

    modport master (
        output rs_id, rt_id, rs_used, rt_used, memread_ex, wsel_ex,
               branch_taken, jump_sel, ihit, dmemreq, dhit,
        input  freeze, flush, hz_state, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_id, rt_id, rs_used, rt_used, memread_ex, wsel_ex,
               branch_taken, jump_sel, ihit, dmemreq, dhit,
        output freeze, flush, hz_state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_param.sv
// Pipeline hazard controller: per-latch freeze/flush for load-use, redirect and memory-wait stalls,
// with a small FSM for multi-cycle stalls and saturating stall/flush counters.
module hazard_ctrl_param #(
    parameter int NLATCH   = 5,
    parameter int REGW     = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNTW     = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_ctrl_param_if.slave hz
);
    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] LDSTALL = 2'd1;
    localparam logic [1:0] DWAIT   = 2'd2;
    localparam logic [2:0] LAT_INIT = 3'(LOAD_LAT - 1);

    logic [1:0]      state_reg, state_next;
    logic [1:0]      resume_reg, resume_next;
    logic [2:0]      ctr_reg, ctr_next;
    logic [CNTW-1:0] stall_cnt_reg, flush_cnt_reg;

    logic [1:0] eff_state;
    logic       dep, redirect, dwait;
    logic       redirect_evt;
    logic [4:0] frz_base, fls_base;

    assign dep = hz.memread_ex && (hz.wsel_ex != '0) &&
                 ((hz.rs_used && (hz.rs_id == hz.wsel_ex)) ||
                  (hz.rt_used && (hz.rt_id == hz.wsel_ex)));
    assign redirect = hz.branch_taken || (hz.jump_sel == 2'd1) || (hz.jump_sel == 2'd2);
    assign dwait    = hz.dmemreq && !hz.dhit;

    // Once the data wait releases, decode as if still in the state that was interrupted.
    assign eff_state = (state_reg == DWAIT) ? resume_reg : state_reg;

    always_comb begin
        state_next   = state_reg;
        resume_next  = resume_reg;
        ctr_next     = ctr_reg;
        frz_base     = 5'b00000;
        fls_base     = 5'b00000;
        redirect_evt = 1'b0;
        if (dwait) begin
            frz_base    = 5'b01111;
            fls_base    = 5'b10000;
            state_next  = DWAIT;
            resume_next = eff_state;
        end else if (redirect) begin
            // Consumer is on the wrong path, so any pending load-use stall is dropped.
            fls_base     = 5'b00110;
            redirect_evt = 1'b1;
            state_next   = RUN;
            ctr_next     = 3'd0;
        end else if (eff_state == LDSTALL) begin
            frz_base = 5'b00011;
            fls_base = 5'b00100;
            if (ctr_reg <= 3'd1) begin
                state_next = RUN;
                ctr_next   = 3'd0;
            end else begin
                state_next = LDSTALL;
                ctr_next   = ctr_reg - 3'd1;
            end
        end else if (dep) begin
            frz_base = 5'b00011;
            fls_base = 5'b00100;
            if (LOAD_LAT > 1) begin
                state_next = LDSTALL;
                ctr_next   = LAT_INIT;
            end else begin
                state_next = RUN;
            end
        end else begin
            state_next = RUN;
            if (!hz.ihit) begin
                frz_base = 5'b00001;
                fls_base = 5'b00010;
            end
        end
    end

    // Latches beyond MEM/WB mirror the MEM/WB controls.
    generate
        for (genvar gi = 0; gi < NLATCH; gi++) begin : g_latch
            if (gi < 5) begin : g_core
                assign hz.freeze[gi] = !rst && frz_base[gi];
                assign hz.flush[gi]  = !rst && fls_base[gi];
            end else begin : g_tail
                assign hz.freeze[gi] = !rst && frz_base[4];
                assign hz.flush[gi]  = !rst && fls_base[4];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            resume_reg    <= RUN;
            ctr_reg       <= 3'd0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            resume_reg <= resume_next;
            ctr_reg    <= ctr_next;
            if ((|frz_base) && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNTW'(1);
            if (redirect_evt && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + CNTW'(1);
        end
    end

    assign hz.hz_state  = state_reg;
    assign hz.stall_cnt = stall_cnt_reg;
    assign hz.flush_cnt = flush_cnt_reg;
endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Directed bench: vector table on a LOAD_LAT=1 instance, hand sequences on LOAD_LAT=3 and a
// LOAD_LAT=4 / 6-latch / 2-bit-counter instance for reset abort and counter saturation.
module tb_hazard_ctrl_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] rs_id, rt_id, wsel_ex;
    logic       rs_used, rt_used, memread_ex, branch_taken, ihit, dmemreq, dhit;
    logic [1:0] jump_sel;

    hazard_ctrl_param_if #(.NLATCH(5), .REGW(5), .CNTW(16)) if1 ();
    hazard_ctrl_param_if #(.NLATCH(5), .REGW(5), .CNTW(16)) if3 ();
    hazard_ctrl_param_if #(.NLATCH(6), .REGW(5), .CNTW(2))  if4 ();

    assign {if1.rs_id, if1.rt_id, if1.rs_used, if1.rt_used, if1.memread_ex, if1.wsel_ex,
            if1.branch_taken, if1.jump_sel, if1.ihit, if1.dmemreq, if1.dhit} =
           {rs_id, rt_id, rs_used, rt_used, memread_ex, wsel_ex, branch_taken, jump_sel, ihit, dmemreq, dhit};
    assign {if3.rs_id, if3.rt_id, if3.rs_used, if3.rt_used, if3.memread_ex, if3.wsel_ex,
            if3.branch_taken, if3.jump_sel, if3.ihit, if3.dmemreq, if3.dhit} =
           {rs_id, rt_id, rs_used, rt_used, memread_ex, wsel_ex, branch_taken, jump_sel, ihit, dmemreq, dhit};
    assign {if4.rs_id, if4.rt_id, if4.rs_used, if4.rt_used, if4.memread_ex, if4.wsel_ex,
            if4.branch_taken, if4.jump_sel, if4.ihit, if4.dmemreq, if4.dhit} =
           {rs_id, rt_id, rs_used, rt_used, memread_ex, wsel_ex, branch_taken, jump_sel, ihit, dmemreq, dhit};

    hazard_ctrl_param #(.NLATCH(5), .REGW(5), .LOAD_LAT(1), .CNTW(16)) u1 (.clk(clk), .rst(rst), .hz(if1.slave));
    hazard_ctrl_param #(.NLATCH(5), .REGW(5), .LOAD_LAT(3), .CNTW(16)) u3 (.clk(clk), .rst(rst), .hz(if3.slave));
    hazard_ctrl_param #(.NLATCH(6), .REGW(5), .LOAD_LAT(4), .CNTW(2))  u4 (.clk(clk), .rst(rst), .hz(if4.slave));

    typedef struct {
        logic       memread;
        logic [4:0] wsel;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic       br;
        logic [1:0] jsel;
        logic       ihit;
        logic       dmemreq;
        logic       dhit;
        logic [4:0] exp_freeze;
        logic [4:0] exp_flush;
        logic [1:0] exp_state;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rs_id = 5'd0; rt_id = 5'd0; wsel_ex = 5'd0;
        rs_used = 1'b0; rt_used = 1'b0; memread_ex = 1'b0; branch_taken = 1'b0;
        jump_sel = 2'd0; ihit = 1'b1; dmemreq = 1'b0; dhit = 1'b1;
    endtask

    task automatic set_dep();
        memread_ex = 1'b1; wsel_ex = 5'd8; rs_id = 5'd8; rs_used = 1'b1;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    task automatic chk3(input string name, input logic [4:0] ef, input logic [4:0] efl, input logic [1:0] es);
        #2;
        chk({name, ".freeze"}, 32'(if3.freeze), 32'(ef));
        chk({name, ".flush"},  32'(if3.flush),  32'(efl));
        chk({name, ".state"},  32'(if3.hz_state), 32'(es));
        $display("u3 %s: freeze=%b flush=%b state=%0d", name, if3.freeze, if3.flush, if3.hz_state);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00000, 2'd0};
        vecs[1]  = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 5'b00011, 5'b00100, 2'd0};
        vecs[2]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 5'b00011, 5'b00100, 2'd0};
        vecs[3]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00000, 2'd0};
        vecs[4]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00000, 2'd0};
        vecs[5]  = '{1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00000, 2'd0};
        vecs[6]  = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00110, 2'd0};
        vecs[7]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00110, 2'd0};
        vecs[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 5'b00000, 5'b00110, 2'd0};
        vecs[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00000, 2'd0};
        vecs[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 5'b00001, 5'b00010, 2'd0};
        vecs[11] = '{1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 5'b00011, 5'b00100, 2'd0};
        vecs[12] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 5'b01111, 5'b10000, 2'd0};
        vecs[13] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 5'b01111, 5'b10000, 2'd2};
        vecs[14] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 5'b00011, 5'b00100, 2'd2};
        vecs[15] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 5'b00000, 5'b00000, 2'd0};
        vecs[16] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00000, 2'd0};

        // Outputs are gated while reset is held, even with a live hazard.
        idle();
        set_dep();
        dmemreq = 1'b1; dhit = 1'b0;
        #2;
        chk("rst.freeze", 32'(if1.freeze), 32'd0);
        chk("rst.flush",  32'(if1.flush),  32'd0);
        do_reset();
        #2;
        chk("rst.state", 32'(if1.hz_state), 32'd0);
        chk("rst.stall_cnt", 32'(if1.stall_cnt), 32'd0);
        chk("rst.flush_cnt", 32'(if1.flush_cnt), 32'd0);

        // Vector table on the LOAD_LAT=1 instance.
        for (int i = 0; i < NVEC; i++) begin
            memread_ex = vecs[i].memread; wsel_ex = vecs[i].wsel;
            rs_id = vecs[i].rs; rt_id = vecs[i].rt;
            rs_used = vecs[i].rs_used; rt_used = vecs[i].rt_used;
            branch_taken = vecs[i].br; jump_sel = vecs[i].jsel;
            ihit = vecs[i].ihit; dmemreq = vecs[i].dmemreq; dhit = vecs[i].dhit;
            #2;
            chk($sformatf("vec%0d.freeze", i), 32'(if1.freeze), 32'(vecs[i].exp_freeze));
            chk($sformatf("vec%0d.flush", i),  32'(if1.flush),  32'(vecs[i].exp_flush));
            chk($sformatf("vec%0d.state", i),  32'(if1.hz_state), 32'(vecs[i].exp_state));
            $display("vec %0d: freeze=%b flush=%b state=%0d", i, if1.freeze, if1.flush, if1.hz_state);
            step();
        end
        #2;
        chk("tbl.stall_cnt", 32'(if1.stall_cnt), 32'd7);
        chk("tbl.flush_cnt", 32'(if1.flush_cnt), 32'd3);

        // LOAD_LAT=3: three bubbles, states 0,1,1 then RUN.
        do_reset();
        set_dep();
        chk3("t2c0", 5'b00011, 5'b00100, 2'd0);
        step(); idle();
        chk3("t2c1", 5'b00011, 5'b00100, 2'd1);
        step();
        chk3("t2c2", 5'b00011, 5'b00100, 2'd1);
        step();
        chk3("t2c3", 5'b00000, 5'b00000, 2'd0);
        chk("t2.stall_cnt", 32'(if3.stall_cnt), 32'd3);

        // Data wait masks a pending dependency, then the load-use stall runs in full.
        do_reset();
        set_dep();
        dmemreq = 1'b1; dhit = 1'b0;
        chk3("t5w0", 5'b01111, 5'b10000, 2'd0);
        for (int k = 1; k < 4; k++) begin
            step();
            chk3($sformatf("t5w%0d", k), 5'b01111, 5'b10000, 2'd2);
        end
        step(); dhit = 1'b1;
        chk3("t5r0", 5'b00011, 5'b00100, 2'd2);
        step(); idle();
        chk3("t5r1", 5'b00011, 5'b00100, 2'd1);
        step();
        chk3("t5r2", 5'b00011, 5'b00100, 2'd1);
        step();
        chk3("t5r3", 5'b00000, 5'b00000, 2'd0);
        chk("t5.stall_cnt", 32'(if3.stall_cnt), 32'd7);

        // Data wait arriving mid-LDSTALL holds the bubble count.
        do_reset();
        set_dep();
        chk3("hold0", 5'b00011, 5'b00100, 2'd0);
        step(); idle(); dmemreq = 1'b1; dhit = 1'b0;
        chk3("hold1", 5'b01111, 5'b10000, 2'd1);
        step();
        chk3("hold2", 5'b01111, 5'b10000, 2'd2);
        step(); dhit = 1'b1;
        chk3("hold3", 5'b00011, 5'b00100, 2'd2);
        step(); idle();
        chk3("hold4", 5'b00011, 5'b00100, 2'd1);
        step();
        chk3("hold5", 5'b00000, 5'b00000, 2'd0);

        // Redirect aborts LDSTALL.
        do_reset();
        set_dep();
        step(); idle(); branch_taken = 1'b1;
        chk3("abort0", 5'b00000, 5'b00110, 2'd1);
        step(); idle();
        chk3("abort1", 5'b00000, 5'b00000, 2'd0);
        chk("abort.flush_cnt", 32'(if3.flush_cnt), 32'd1);

        // LOAD_LAT=4: reset mid-stall, then 2-bit stall counter saturation and wide latch mirror.
        do_reset();
        set_dep();
        step(); idle();
        step();
        #2;
        chk("t6.pre_state", 32'(if4.hz_state), 32'd1);
        chk("t6.pre_freeze", 32'(if4.freeze), 32'h03);
        rst = 1'b1;
        #1;
        chk("t6.rst_freeze", 32'(if4.freeze), 32'd0);
        chk("t6.rst_flush",  32'(if4.flush),  32'd0);
        step(); rst = 1'b0;
        #2;
        chk("t6.state", 32'(if4.hz_state), 32'd0);
        chk("t6.stall_cnt", 32'(if4.stall_cnt), 32'd0);
        chk("t6.flush_cnt", 32'(if4.flush_cnt), 32'd0);
        ihit = 1'b0;
        step(); step();
        #2;
        chk("sat.two", 32'(if4.stall_cnt), 32'd2);
        step(); step(); step();
        #2;
        chk("sat.hold", 32'(if4.stall_cnt), 32'd3);
        idle(); dmemreq = 1'b1; dhit = 1'b0;
        #2;
        chk("wide.freeze", 32'(if4.freeze), 32'h0F);
        chk("wide.flush",  32'(if4.flush),  32'h30);
        $display("u4 wide: freeze=%b flush=%b", if4.freeze, if4.flush);
        step(); idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
